// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and default counts for the button press decoder
package button_pkg;
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_LONG_COUNT   = 16;
  localparam int DEF_REPEAT_COUNT = 4;
  localparam int DEF_DOUBLE_GAP   = 8;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: previous-sample register and arming flag that qualify button edges
//   clk, reset (async active-low), button_in -> rise (armed press edge), fall (release edge)
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic rise,
  output logic fall
);
  logic btn_q, armed;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      btn_q <= button_in;
      armed <= armed | ~button_in;
    end
  end
  // a button already down at reset release must be seen low once before it can press
  assign rise = armed & button_in & ~btn_q;
  assign fall = btn_q & ~button_in;
endmodule

// File: rtl/button_press_decoder.sv
// button_press_decoder: turns a debounced button level into press/release/click/long/repeat pulses
//   clk, reset (async active-low), button_in -> one-cycle event pulses plus the held level
module button_press_decoder
  import button_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LONG_COUNT   = DEF_LONG_COUNT,
  parameter int REPEAT_COUNT = DEF_REPEAT_COUNT,
  parameter int DOUBLE_GAP   = DEF_DOUBLE_GAP
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);
  state_t state;
  logic [CNT_W-1:0] hold_cnt, gap_cnt, rep_cnt, hold_inc, gap_inc, rep_inc;
  logic rise, fall;
  edge_detect u_edge (.clk(clk), .reset(reset), .button_in(button_in), .rise(rise), .fall(fall));
  // saturating increments so long holds never wrap back into a short press
  assign hold_inc = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
  assign gap_inc  = &gap_cnt  ? gap_cnt  : gap_cnt  + 1'b1;
  assign rep_inc  = &rep_cnt  ? rep_cnt  : rep_cnt  + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      double_press  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      double_press  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          press_pulse <= 1'b1;
          held        <= 1'b1;
          hold_cnt    <= CNT_W'(1);
          state       <= PRESSED;
        end
        PRESSED: if (fall) begin
          release_pulse <= 1'b1;
          held          <= 1'b0;
          if (DOUBLE_GAP == 0) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end else begin
            gap_cnt <= CNT_W'(1);
            state   <= WAIT_SECOND;
          end
        end else begin
          hold_cnt <= hold_inc;
          if (hold_inc >= CNT_W'(LONG_COUNT)) begin
            long_press <= 1'b1;
            rep_cnt    <= '0;
            state      <= LONG_HELD;
          end
        end
        LONG_HELD: if (fall) begin
          release_pulse <= 1'b1;
          held          <= 1'b0;
          state         <= IDLE;
        end else if (rep_inc >= CNT_W'(REPEAT_COUNT)) begin
          repeat_pulse <= 1'b1;
          rep_cnt      <= '0;
        end else begin
          rep_cnt <= rep_inc;
        end
        // a second press wins over the gap expiring on the same sample
        WAIT_SECOND: if (rise) begin
          press_pulse <= 1'b1;
          held        <= 1'b1;
          hold_cnt    <= CNT_W'(1);
          state       <= SECOND_PRESSED;
        end else if (!button_in) begin
          gap_cnt <= gap_inc;
          if (gap_inc >= CNT_W'(DOUBLE_GAP)) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end
        end
        SECOND_PRESSED: if (fall) begin
          release_pulse <= 1'b1;
          double_press  <= 1'b1;
          held          <= 1'b0;
          state         <= IDLE;
        end else begin
          hold_cnt <= hold_inc;
          // the first click is still owed its short_press when the second becomes a long hold
          if (hold_inc >= CNT_W'(LONG_COUNT)) begin
            short_press <= 1'b1;
            long_press  <= 1'b1;
            rep_cnt     <= '0;
            state       <= LONG_HELD;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: directed-vector bench for button_press_decoder (gap 8 and gap 0 instances)
module tb_button_press_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic btn0 = 1'b0;
  logic p, r, s, d, l, rp, h;
  logic p0, r0, s0, d0, l0, rp0, h0;
  logic [6:0] outs, outs0;
  int checks = 0;
  int passes = 0;
  button_press_decoder #(.CNT_W(16), .LONG_COUNT(16), .REPEAT_COUNT(4), .DOUBLE_GAP(8)) dut (
    .clk(clk), .reset(reset), .button_in(btn), .press_pulse(p), .release_pulse(r),
    .short_press(s), .double_press(d), .long_press(l), .repeat_pulse(rp), .held(h)
  );
  button_press_decoder #(.CNT_W(16), .LONG_COUNT(16), .REPEAT_COUNT(4), .DOUBLE_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .button_in(btn0), .press_pulse(p0), .release_pulse(r0),
    .short_press(s0), .double_press(d0), .long_press(l0), .repeat_pulse(rp0), .held(h0)
  );
  // bit order: press, release, short, double, long, repeat, held
  assign outs  = {p, r, s, d, l, rp, h};
  assign outs0 = {p0, r0, s0, d0, l0, rp0, h0};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
  endtask
  task automatic seq(input string tag, input bit inst, input logic b, input int n, input logic [6:0] e);
    for (int i = 0; i < n; i++) begin
      if (inst) btn0 = b;
      else btn = b;
      @(posedge clk);
      #1;
      check(tag, inst ? outs0 : outs, e);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", outs, 7'b0);
    check("reset0", outs0, 7'b0);
    reset = 1'b1;
    seq("arm", 0, 1'b0, 2, 7'b0);
    seq("s1_press", 0, 1'b1, 1, 7'b1000001);
    seq("s1_hold", 0, 1'b1, 4, 7'b0000001);
    seq("s1_rel", 0, 1'b0, 1, 7'b0100000);
    seq("s1_gap", 0, 1'b0, 6, 7'b0);
    seq("s1_short", 0, 1'b0, 1, 7'b0010000);
    seq("s1_idle", 0, 1'b0, 3, 7'b0);
    seq("s2_press", 0, 1'b1, 1, 7'b1000001);
    seq("s2_hold", 0, 1'b1, 14, 7'b0000001);
    seq("s2_long", 0, 1'b1, 1, 7'b0000101);
    seq("s2_held", 0, 1'b1, 3, 7'b0000001);
    seq("s2_rep1", 0, 1'b1, 1, 7'b0000011);
    seq("s2_held", 0, 1'b1, 3, 7'b0000001);
    seq("s2_rep2", 0, 1'b1, 1, 7'b0000011);
    seq("s2_rel", 0, 1'b0, 1, 7'b0100000);
    seq("s2_noshort", 0, 1'b0, 10, 7'b0);
    seq("s3_press1", 0, 1'b1, 1, 7'b1000001);
    seq("s3_hold1", 0, 1'b1, 2, 7'b0000001);
    seq("s3_rel1", 0, 1'b0, 1, 7'b0100000);
    seq("s3_gap", 0, 1'b0, 3, 7'b0);
    seq("s3_press2", 0, 1'b1, 1, 7'b1000001);
    seq("s3_hold2", 0, 1'b1, 2, 7'b0000001);
    seq("s3_double", 0, 1'b0, 1, 7'b0101000);
    seq("s3_idle", 0, 1'b0, 10, 7'b0);
    seq("s4a_press1", 0, 1'b1, 1, 7'b1000001);
    seq("s4a_hold1", 0, 1'b1, 2, 7'b0000001);
    seq("s4a_rel1", 0, 1'b0, 1, 7'b0100000);
    seq("s4a_gap", 0, 1'b0, 6, 7'b0);
    seq("s4a_press2", 0, 1'b1, 1, 7'b1000001);
    seq("s4a_double", 0, 1'b0, 1, 7'b0101000);
    seq("s4a_idle", 0, 1'b0, 10, 7'b0);
    seq("s4b_press1", 0, 1'b1, 1, 7'b1000001);
    seq("s4b_hold1", 0, 1'b1, 2, 7'b0000001);
    seq("s4b_rel1", 0, 1'b0, 1, 7'b0100000);
    seq("s4b_gap", 0, 1'b0, 6, 7'b0);
    seq("s4b_short", 0, 1'b0, 1, 7'b0010000);
    seq("s4b_newpress", 0, 1'b1, 1, 7'b1000001);
    seq("s4b_rel", 0, 1'b0, 1, 7'b0100000);
    seq("s4b_gap2", 0, 1'b0, 6, 7'b0);
    seq("s4b_short2", 0, 1'b0, 1, 7'b0010000);
    seq("s5_press", 0, 1'b1, 1, 7'b1000001);
    seq("s5_hold", 0, 1'b1, 14, 7'b0000001);
    seq("s5_long", 0, 1'b1, 1, 7'b0000101);
    seq("s5_held", 0, 1'b1, 2, 7'b0000001);
    reset = 1'b0;
    #1;
    check("s5_async_rst", outs, 7'b0);
    repeat (3) @(posedge clk);
    #1;
    check("s5_in_rst", outs, 7'b0);
    reset = 1'b1;
    seq("s5_no_rearm", 0, 1'b1, 3, 7'b0);
    seq("s5_arm", 0, 1'b0, 1, 7'b0);
    seq("s5_press2", 0, 1'b1, 1, 7'b1000001);
    seq("s5_rel", 0, 1'b0, 1, 7'b0100000);
    seq("s5_gap", 0, 1'b0, 6, 7'b0);
    seq("s5_short", 0, 1'b0, 1, 7'b0010000);
    check("g0_quiet", outs0, 7'b0);
    seq("g0_press", 1, 1'b1, 1, 7'b1000001);
    seq("g0_hold", 1, 1'b1, 2, 7'b0000001);
    seq("g0_rel_short", 1, 1'b0, 1, 7'b0110000);
    seq("g0_idle", 1, 1'b0, 10, 7'b0);
    check("g0_main_idle", outs, 7'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
